// File: rtl/tsc_mem_model.sv
// Parametrised clocked memory for TSC CPU benches: latency-configurable reads/writes
// with single-cycle response pulses, completion counters and a backdoor load port.
module tsc_mem_model #(
  parameter int WORD_SIZE     = 16,
  parameter int ADDR_WIDTH    = 8,
  parameter int READ_LATENCY  = 3,
  parameter int WRITE_LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  readM,
  input  logic                  writeM,
  input  logic [WORD_SIZE-1:0]  address,
  input  logic [WORD_SIZE-1:0]  data_in,
  output logic [WORD_SIZE-1:0]  data_out,
  output logic                  inputReady,
  output logic                  ackOutput,
  output logic                  busy,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [WORD_SIZE-1:0]  load_data,
  output logic [WORD_SIZE-1:0]  rd_count,
  output logic [WORD_SIZE-1:0]  wr_count
);

  localparam int DEPTH   = 1 << ADDR_WIDTH;
  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_isRead;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WORD_SIZE-1:0]  r_wdata;
  logic [WORD_SIZE-1:0]  r_dataOut;
  logic                  r_inputReady;
  logic                  r_ackOutput;
  logic                  r_busy;
  logic [WORD_SIZE-1:0]  r_rdCount;
  logic [WORD_SIZE-1:0]  r_wrCount;
  logic [WORD_SIZE-1:0]  r_mem [0:DEPTH-1];

  logic w_wrCommit;

  // Upper address bits are deliberately ignored so addresses alias modulo DEPTH.
  if (WORD_SIZE > ADDR_WIDTH) begin : gAddrHi
    logic w_unusedAddrHi;
    assign w_unusedAddrHi = ^address[WORD_SIZE-1:ADDR_WIDTH];
  end

  assign w_wrCommit = (r_state == BUSY) && (r_cnt == '0) && !r_isRead;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_isRead     <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_dataOut    <= '0;
      r_inputReady <= 1'b0;
      r_ackOutput  <= 1'b0;
      r_busy       <= 1'b0;
      r_rdCount    <= '0;
      r_wrCount    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (readM) begin
            r_addr   <= address[ADDR_WIDTH-1:0];
            r_isRead <= 1'b1;
            r_cnt    <= CNT_W'(READ_LATENCY - 1);
            r_state  <= BUSY;
            r_busy   <= 1'b1;
          end else if (writeM) begin
            r_addr   <= address[ADDR_WIDTH-1:0];
            r_wdata  <= data_in;
            r_isRead <= 1'b0;
            r_cnt    <= CNT_W'(WRITE_LATENCY - 1);
            r_state  <= BUSY;
            r_busy   <= 1'b1;
          end
        end
        BUSY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            if (r_isRead) begin
              r_dataOut    <= r_mem[r_addr];
              r_inputReady <= 1'b1;
              r_rdCount    <= r_rdCount + 1'b1;
            end else begin
              r_ackOutput <= 1'b1;
              r_wrCount   <= r_wrCount + 1'b1;
            end
            r_state <= RESP;
          end
        end
        RESP: begin
          r_inputReady <= 1'b0;
          r_ackOutput  <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Front-end commit is written last so it overrides a same-index backdoor load.
  always_ff @(posedge clk) begin
    if (load_en) begin
      r_mem[load_addr] <= load_data;
    end
    if (w_wrCommit) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

  assign data_out   = r_dataOut;
  assign inputReady = r_inputReady;
  assign ackOutput  = r_ackOutput;
  assign busy       = r_busy;
  assign rd_count   = r_rdCount;
  assign wr_count   = r_wrCount;

endmodule
